// File: rtl/regf_mp.sv
// regf_mp: multi-port register file with write-to-read bypass, busy scoreboard and debug tap
module regf_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int BYPASS     = 1,
  parameter int DBG_REG    = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wa,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wd,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  output logic [ADDR_WIDTH:0]          busy_cnt,
  output logic [DATA_WIDTH-1:0]        dbg_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] DBG_A = ADDR_WIDTH'(DBG_REG);
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy, busy_nxt, clr, set;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  // Issue is applied after write-clear so a newly issued producer keeps the register busy
  always_comb begin
    clr = '0;
    for (int j = 0; j < NUM_WR; j++)
      if (we[j]) clr[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
    set = '0;
    if (iss_en) set[iss_addr] = 1'b1;
    busy_nxt = ((busy & ~clr) | set) & ~DEPTH'(1);
    cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(busy_nxt[r]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  // Later ports are visited last, so the highest enabled port wins a collision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (we[j] && wa[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)
          regs[wa[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wd[j*DATA_WIDTH +: DATA_WIDTH];
    end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    assign a = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    always_comb begin
      d = regs[a];
      for (int j = 0; j < NUM_WR; j++)
        if (BYPASS != 0 && we[j] && wa[j*ADDR_WIDTH +: ADDR_WIDTH] == a) d = wd[j*DATA_WIDTH +: DATA_WIDTH];
    end
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = (a == '0) ? '0 : d;
    assign rd_busy[i] = busy[a];
  end
  assign dbg_data = regs[DBG_A];
endmodule

// File: tb/tb_regf_mp.sv
// tb_regf_mp: randomized and directed checks of regf_mp (bypass and non-bypass builds) against an array model
module tb_regf_mp;
  localparam int DW = 32, AW = 5, NR = 2, NW = 2, DEPTH = 32, DBG = 10;
  logic            clk = 0, rst_n = 1;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NW-1:0]    we = '0;
  logic [NW*AW-1:0] wa = '0;
  logic [NW*DW-1:0] wd = '0;
  logic             iss_en = 0;
  logic [AW-1:0]    iss_addr = '0;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic [AW:0]      busy_cnt_b, busy_cnt_n;
  logic [DW-1:0]    dbg_b, dbg_n;
  int checks = 0, errors = 0;
  logic [DW-1:0] mreg [DEPTH];
  bit            mbusy [DEPTH];

  regf_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .DBG_REG(DBG)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt_b), .dbg_data(dbg_b));
  regf_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .DBG_REG(DBG)) u_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt_n), .dbg_data(dbg_n));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input int p, input bit byp);
    logic [AW-1:0] a;
    a = rd_addr[p*AW +: AW];
    if (a == 0) return '0;
    if (byp)
      for (int j = NW - 1; j >= 0; j--)
        if (we[j] && wa[j*AW +: AW] == a) return wd[j*DW +: DW];
    return mreg[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(mbusy[r]);
    return n;
  endfunction

  function automatic bit exp_busy(input int p);
    return mbusy[rd_addr[p*AW +: AW]];
  endfunction

  task automatic m_clear();
    for (int r = 0; r < DEPTH; r++) begin
      mreg[r] = '0;
      mbusy[r] = 0;
    end
  endtask

  task automatic m_update();
    for (int j = 0; j < NW; j++)
      if (we[j] && wa[j*AW +: AW] != 0) begin
        mreg[wa[j*AW +: AW]] = wd[j*DW +: DW];
        mbusy[wa[j*AW +: AW]] = 0;
      end
    if (iss_en && iss_addr != 0) mbusy[iss_addr] = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_update();
    #2;
  endtask

  task automatic idle();
    we = '0; wa = '0; wd = '0; iss_en = 0; iss_addr = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    wa[p*AW +: AW] = a;
    wd[p*DW +: DW] = d;
  endtask

  task automatic test_reset();
    idle();
    rd_addr = {5'd6, 5'd5};
    #1 rst_n = 0;
    m_clear();
    #2;
    checks++; if (rd_data_b !== '0 || rd_data_n !== '0) begin errors++; $display("FAIL reset_rd got %h/%h exp 0", rd_data_b, rd_data_n); end
    checks++; if (busy_cnt_b !== '0 || rd_busy_b !== '0 || dbg_b !== '0) begin errors++; $display("FAIL reset_busy got cnt %0d busy %b dbg %h exp 0", busy_cnt_b, rd_busy_b, dbg_b); end
    @(negedge clk) rst_n = 1;
    wr(0, 5'd5, 32'h1234);
    iss_en = 1; iss_addr = 5'd5;
    tick();
    idle();
    #1;
    checks++; if (rd_data_n[DW-1:0] !== 32'h1234 || rd_data_b[DW-1:0] !== 32'h1234) begin errors++; $display("FAIL preload got %h/%h exp 00001234", rd_data_b[DW-1:0], rd_data_n[DW-1:0]); end
    checks++; if (busy_cnt_b !== 6'd1) begin errors++; $display("FAIL preload_cnt got %0d exp 1", busy_cnt_b); end
    wr(0, 5'd6, 32'hFFFF);
    #1 rst_n = 0;
    m_clear();
    #1;
    checks++; if (rd_data_n[DW-1:0] !== '0 || rd_data_b[DW-1:0] !== '0) begin errors++; $display("FAIL async_reset_rd got %h/%h exp 0", rd_data_b[DW-1:0], rd_data_n[DW-1:0]); end
    checks++; if (busy_cnt_b !== '0 || busy_cnt_n !== '0) begin errors++; $display("FAIL async_reset_cnt got %0d/%0d exp 0", busy_cnt_b, busy_cnt_n); end
    tick();
    idle();
    #2 rst_n = 1;
    #1;
    checks++; if (rd_data_n[DW +: DW] !== '0 || rd_data_b[DW +: DW] !== '0) begin errors++; $display("FAIL reset_discard got %h/%h exp 0", rd_data_b[DW +: DW], rd_data_n[DW +: DW]); end
  endtask

  task automatic test_x0();
    idle();
    rd_addr = '0;
    wr(1, 5'd0, 32'hFFFFFFFF);
    iss_en = 1; iss_addr = 5'd0;
    #1;
    checks++; if (rd_data_b !== '0) begin errors++; $display("FAIL x0_bypass got %h exp 0", rd_data_b); end
    tick();
    idle();
    #1;
    checks++; if (rd_data_b !== '0 || rd_data_n !== '0 || rd_busy_b !== '0) begin errors++; $display("FAIL x0_read got %h/%h busy %b exp 0", rd_data_b, rd_data_n, rd_busy_b); end
    checks++; if (busy_cnt_b !== '0 || busy_cnt_n !== '0) begin errors++; $display("FAIL x0_cnt got %0d/%0d exp 0", busy_cnt_b, busy_cnt_n); end
  endtask

  task automatic test_bypass();
    idle();
    rd_addr = {5'd0, 5'd7};
    wr(0, 5'd7, 32'h1);
    tick();
    idle();
    wr(0, 5'd7, 32'hDEADBEEF);
    #1;
    checks++; if (rd_data_b[DW-1:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same got %h exp deadbeef", rd_data_b[DW-1:0]); end
    checks++; if (rd_data_n[DW-1:0] !== 32'h1) begin errors++; $display("FAIL nobypass_old got %h exp 00000001", rd_data_n[DW-1:0]); end
    tick();
    idle();
    #1;
    checks++; if (rd_data_n[DW-1:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL nobypass_next got %h exp deadbeef", rd_data_n[DW-1:0]); end
  endtask

  task automatic test_collision();
    idle();
    rd_addr = {5'd3, 5'd0};
    wr(0, 5'd3, 32'h11);
    wr(1, 5'd3, 32'h22);
    #1;
    checks++; if (rd_data_b[DW +: DW] !== 32'h22) begin errors++; $display("FAIL coll_bypass got %h exp 00000022", rd_data_b[DW +: DW]); end
    tick();
    idle();
    #1;
    checks++; if (rd_data_b[DW +: DW] !== 32'h22 || rd_data_n[DW +: DW] !== 32'h22) begin errors++; $display("FAIL coll_store got %h/%h exp 00000022", rd_data_b[DW +: DW], rd_data_n[DW +: DW]); end
  endtask

  task automatic test_scoreboard();
    idle();
    rd_addr = {5'd0, 5'd9};
    iss_en = 1; iss_addr = 5'd9;
    #1;
    checks++; if (rd_busy_b[0] !== 1'b0) begin errors++; $display("FAIL sb_no_bypass got %b exp 0", rd_busy_b[0]); end
    tick();
    idle();
    #1;
    checks++; if (rd_busy_b[0] !== 1'b1 || busy_cnt_b !== 6'd1) begin errors++; $display("FAIL sb_issue got busy %b cnt %0d exp 1 1", rd_busy_b[0], busy_cnt_b); end
    wr(0, 5'd9, 32'h99);
    iss_en = 1; iss_addr = 5'd9;
    tick();
    idle();
    #1;
    checks++; if (rd_busy_n[0] !== 1'b1 || busy_cnt_n !== 6'd1) begin errors++; $display("FAIL sb_set_wins got busy %b cnt %0d exp 1 1", rd_busy_n[0], busy_cnt_n); end
    wr(1, 5'd9, 32'h98);
    tick();
    idle();
    #1;
    checks++; if (rd_busy_b[0] !== 1'b0 || busy_cnt_b !== 6'd0) begin errors++; $display("FAIL sb_clear got busy %b cnt %0d exp 0 0", rd_busy_b[0], busy_cnt_b); end
  endtask

  task automatic test_debug();
    idle();
    wr(1, 5'd10, 32'h42);
    #1;
    checks++; if (dbg_b !== 32'h0) begin errors++; $display("FAIL dbg_early got %h exp 0", dbg_b); end
    tick();
    idle();
    #1;
    checks++; if (dbg_b !== 32'h42 || dbg_n !== 32'h42) begin errors++; $display("FAIL dbg_tap got %h/%h exp 00000042", dbg_b, dbg_n); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we = NW'($urandom);
      wa[AW-1:0] = AW'($urandom_range(0, 15));
      wa[AW +: AW] = ($urandom_range(0, 3) == 0) ? wa[AW-1:0] : AW'($urandom_range(0, 15));
      wd = {$urandom, $urandom};
      iss_en = $urandom_range(0, 1) == 1;
      iss_addr = AW'($urandom_range(0, 15));
      for (int p = 0; p < NR; p++)
        rd_addr[p*AW +: AW] = ($urandom_range(0, 2) == 0) ? wa[($urandom_range(0, 1))*AW +: AW] : AW'($urandom_range(0, 15));
      #1;
      for (int p = 0; p < NR; p++) begin
        checks++; if (rd_data_b[p*DW +: DW] !== exp_rd(p, 1)) begin errors++; $display("FAIL rand_rd_b p%0d got %h exp %h", p, rd_data_b[p*DW +: DW], exp_rd(p, 1)); end
        checks++; if (rd_data_n[p*DW +: DW] !== exp_rd(p, 0)) begin errors++; $display("FAIL rand_rd_n p%0d got %h exp %h", p, rd_data_n[p*DW +: DW], exp_rd(p, 0)); end
        checks++; if (rd_busy_b[p] !== exp_busy(p)) begin errors++; $display("FAIL rand_busy p%0d got %b exp %b", p, rd_busy_b[p], exp_busy(p)); end
      end
      checks++; if (int'(busy_cnt_b) !== exp_cnt()) begin errors++; $display("FAIL rand_cnt got %0d exp %0d", busy_cnt_b, exp_cnt()); end
      checks++; if (dbg_n !== mreg[DBG]) begin errors++; $display("FAIL rand_dbg got %h exp %h", dbg_n, mreg[DBG]); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_x0();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_debug();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
